// File: rtl/param_frame_sender.sv
// Transmit side of the 5-byte parameter-frame link: snapshots X/Y/Zoom/Angle/Count on START
// and serialises them as TByt0/TValid, then waits for the loader's FINISH_READ and FINISH.
// Optional feature: define SG_AUTO_RESEND_EN to re-send the snapshot after every FINISH.
module param_frame_sender #(
    parameter int VALID_CYCLES = 2,
    parameter int GAP_CYCLES   = 2,
    parameter int ACK_TIMEOUT  = 255
) (
    input  logic       ACLK,
    input  logic       RESET,
    input  logic       START,
    input  logic       ABORT,
    input  logic [7:0] X_center,
    input  logic [7:0] Y_center,
    input  logic [7:0] Zoom,
    input  logic [7:0] Angle,
    input  logic [7:0] Count,
    input  logic       FINISH_READ,
    input  logic       FINISH,
    output logic [7:0] TByt0,
    output logic       TValid,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR
);

    localparam int NBYTES = 5;
    localparam int PH_MAX = (VALID_CYCLES > GAP_CYCLES) ? VALID_CYCLES : GAP_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        GAP,
        WAIT_ACK,
        WAIT_FIN
    } state_t;

    state_t          state_reg, state_next;
    logic [2:0]      idx_reg, idx_next;
    logic [PH_W-1:0] ph_reg, ph_next;
    logic [7:0]      to_cnt_reg, to_cnt_next;
    logic [7:0]      tbyt_reg, tbyt_next;
    logic            tvalid_reg, tvalid_next;
    logic            done_reg, done_next;
    logic            err_reg, err_next;
    logic            load_snap;

    logic [7:0]      frame_in [NBYTES];
    logic [7:0]      snap_reg [NBYTES];

    assign frame_in[0] = X_center;
    assign frame_in[1] = Y_center;
    assign frame_in[2] = Zoom;
    assign frame_in[3] = Angle;
    assign frame_in[4] = Count;

    // Snapshot is taken only on an accepted START; inputs may change afterwards.
    always_ff @(posedge ACLK) begin
        for (int i = 0; i < NBYTES; i++) begin
            if (RESET) begin
                snap_reg[i] <= '0;
            end else if (load_snap) begin
                snap_reg[i] <= frame_in[i];
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (RESET) begin
            state_reg  <= IDLE;
            idx_reg    <= '0;
            ph_reg     <= '0;
            to_cnt_reg <= '0;
            tbyt_reg   <= '0;
            tvalid_reg <= 1'b0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            ph_reg     <= ph_next;
            to_cnt_reg <= to_cnt_next;
            tbyt_reg   <= tbyt_next;
            tvalid_reg <= tvalid_next;
            done_reg   <= done_next;
            err_reg    <= err_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        ph_next     = ph_reg;
        to_cnt_next = to_cnt_reg;
        tbyt_next   = tbyt_reg;
        tvalid_next = tvalid_reg;
        done_next   = 1'b0;
        err_next    = err_reg;
        load_snap   = 1'b0;

        if (ABORT && (state_reg != IDLE)) begin
            state_next  = IDLE;
            tvalid_next = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (START) begin
                        // Byte 0 goes out on the accepting edge, straight from the inputs.
                        load_snap   = 1'b1;
                        idx_next    = '0;
                        ph_next     = '0;
                        err_next    = 1'b0;
                        tbyt_next   = X_center;
                        tvalid_next = 1'b1;
                        state_next  = DRIVE;
                    end
                end
                DRIVE: begin
                    if (ph_reg == PH_W'(VALID_CYCLES - 1)) begin
                        ph_next     = '0;
                        tvalid_next = 1'b0;
                        state_next  = GAP;
                    end else begin
                        ph_next = ph_reg + 1'b1;
                    end
                end
                GAP: begin
                    if (ph_reg == PH_W'(GAP_CYCLES - 1)) begin
                        ph_next = '0;
                        if (idx_reg < 3'(NBYTES - 1)) begin
                            // Data changes only together with the rising strobe.
                            idx_next    = idx_reg + 3'd1;
                            tbyt_next   = snap_reg[idx_reg + 3'd1];
                            tvalid_next = 1'b1;
                            state_next  = DRIVE;
                        end else begin
                            to_cnt_next = '0;
                            state_next  = WAIT_ACK;
                        end
                    end else begin
                        ph_next = ph_reg + 1'b1;
                    end
                end
                WAIT_ACK: begin
                    if (FINISH_READ) begin
                        state_next = WAIT_FIN;
                    end else if (to_cnt_reg == 8'(ACK_TIMEOUT - 1)) begin
                        err_next   = 1'b1;
                        state_next = IDLE;
                    end else if (to_cnt_reg != 8'hFF) begin
                        to_cnt_next = to_cnt_reg + 8'd1;
                    end
                end
                WAIT_FIN: begin
                    if (FINISH) begin
                        done_next = 1'b1;
`ifdef SG_AUTO_RESEND_EN
                        idx_next    = '0;
                        ph_next     = '0;
                        tbyt_next   = snap_reg[0];
                        tvalid_next = 1'b1;
                        state_next  = DRIVE;
`else
                        state_next  = IDLE;
`endif
                    end
                end
                default: begin
                    state_next  = IDLE;
                    tvalid_next = 1'b0;
                end
            endcase
        end
    end

    assign TByt0  = tbyt_reg;
    assign TValid = tvalid_reg;
    assign BUSY   = (state_reg != IDLE);
    assign DONE   = done_reg;
    assign ERR    = err_reg;

endmodule

// File: tb/tb_param_frame_sender.sv
// Directed bench for param_frame_sender: a frame-timeline model checked every cycle,
// a small loader model, and hand-computed literal expectations.
module tb_param_frame_sender;

    localparam int VC     = 2;
    localparam int GC     = 2;
    localparam int TO     = 255;
    localparam int PERIOD = VC + GC;
    localparam int FRAME  = 5 * PERIOD;

    logic       ACLK = 1'b0;
    logic       RESET = 1'b1;
    logic       START = 1'b0;
    logic       ABORT = 1'b0;
    logic [7:0] X_center = '0, Y_center = '0, Zoom = '0, Angle = '0, Count = '0;
    logic       FINISH_READ = 1'b0;
    logic       FINISH = 1'b0;
    logic [7:0] TByt0;
    logic       TValid, BUSY, DONE, ERR;

    param_frame_sender #(
        .VALID_CYCLES(VC),
        .GAP_CYCLES  (GC),
        .ACK_TIMEOUT (TO)
    ) dut (
        .ACLK       (ACLK),
        .RESET      (RESET),
        .START      (START),
        .ABORT      (ABORT),
        .X_center   (X_center),
        .Y_center   (Y_center),
        .Zoom       (Zoom),
        .Angle      (Angle),
        .Count      (Count),
        .FINISH_READ(FINISH_READ),
        .FINISH     (FINISH),
        .TByt0      (TByt0),
        .TValid     (TValid),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .ERR        (ERR)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1 sending (m_t = 1..FRAME cycles into the frame), 2 await ack,
    // 3 await finish. Byte and strobe follow from the position in the frame.
    int         m_phase = 0;
    int         m_t = 0;
    int         m_ackcnt = 0;
    logic [7:0] m_snap [5];
    logic [7:0] m_hold = '0;
    logic       m_err = 1'b0;
    logic       m_done = 1'b0;

    always @(posedge ACLK) begin
        m_done <= 1'b0;
        if (RESET) begin
            m_phase <= 0;
            m_t     <= 0;
            m_hold  <= '0;
            m_err   <= 1'b0;
            for (int i = 0; i < 5; i++) m_snap[i] <= '0;
        end else if (ABORT && m_phase != 0) begin
            if (m_phase == 1) m_hold <= m_snap[(m_t - 1) / PERIOD];
            m_phase <= 0;
        end else begin
            case (m_phase)
                0: if (START) begin
                    m_snap[0] <= X_center;
                    m_snap[1] <= Y_center;
                    m_snap[2] <= Zoom;
                    m_snap[3] <= Angle;
                    m_snap[4] <= Count;
                    m_t       <= 1;
                    m_phase   <= 1;
                    m_err     <= 1'b0;
                end
                1: if (m_t == FRAME) begin
                    m_phase  <= 2;
                    m_ackcnt <= 0;
                    m_hold   <= m_snap[4];
                end else begin
                    m_t <= m_t + 1;
                end
                2: if (FINISH_READ) begin
                    m_phase <= 3;
                end else if (m_ackcnt == TO - 1) begin
                    m_err   <= 1'b1;
                    m_phase <= 0;
                end else begin
                    m_ackcnt <= m_ackcnt + 1;
                end
                default: if (FINISH) begin
                    m_done <= 1'b1;
`ifdef SG_AUTO_RESEND_EN
                    m_phase <= 1;
                    m_t     <= 1;
`else
                    m_phase <= 0;
`endif
                end
            endcase
        end
    end

    always @(negedge ACLK) begin
        if (cmp_en) begin
            check("model_tbyt", TByt0,
                  (m_phase == 1) ? m_snap[(m_t - 1) / PERIOD] : m_hold);
            check("model_tvalid", TValid, (m_phase == 1) && (((m_t - 1) % PERIOD) < VC));
            check("model_busy", BUSY, m_phase != 0);
            check("model_done", DONE, m_done);
            check("model_err", ERR, m_err);
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic set_frame(input logic [7:0] x, y, z, a, c);
        X_center = x; Y_center = y; Zoom = z; Angle = a; Count = c;
    endtask

    // Pulses START; returns in cycle 1 of the frame.
    task automatic start_frame();
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int         cyc, nb, lc, rises, last_hi;
        bit         pending, prev;
        logic [7:0] lb [5];

        // Reset state
        tick();
        cmp_en = 1'b1;
        tick();
        check("reset_tbyt", TByt0, 8'h00);
        check("reset_tvalid", TValid, 1'b0);
        check("reset_busy", BUSY, 1'b0);
        check("reset_done", DONE, 1'b0);
        check("reset_err", ERR, 1'b0);
        RESET = 1'b0;
        tick();

        // Frame with loader handshake
        set_frame(8'h11, 8'h22, 8'h33, 8'h44, 8'h02);
        start_frame();
        cyc = 1; nb = 0; pending = 1'b0; prev = 1'b0;
        check("c1_tvalid", TValid, 1'b1);
        check("c1_tbyt", TByt0, 8'h11);
        check("c1_busy", BUSY, 1'b1);
        while (nb < 5 && cyc < 60) begin
            if (pending) begin
                lb[nb] = TByt0;
                nb++;
                pending = 1'b0;
            end
            if (TValid && !prev) pending = 1'b1;
            prev = TValid;
            if (cyc == 3)  check("c3_tvalid", TValid, 1'b0);
            if (cyc == 6)  check("c6_tbyt", TByt0, 8'h22);
            if (cyc == 13) check("c13_tbyt", TByt0, 8'h44);
            if (cyc == 16) check("c16_tvalid", TValid, 1'b0);
            if (cyc == 17) check("c17_tbyt", TByt0, 8'h02);
            if (nb < 5) begin
                tick();
                cyc++;
            end
        end
        check("loader_nbytes", nb, 5);
        FINISH_READ = 1'b1;
        lc = (nb == 5) ? int'(lb[4]) : 0;
        for (int k = 0; k < 8 && lc > 0; k++) begin
            repeat (4) tick();
            lc--;
        end
        check("loader_count_left", lc, 0);
        FINISH = 1'b1;
        tick();
        FINISH = 1'b0;
        FINISH_READ = 1'b0;
        check("fin_done", DONE, 1'b1);
`ifdef SG_AUTO_RESEND_EN
        check("resend_busy", BUSY, 1'b1);
        check("resend_tvalid", TValid, 1'b1);
        check("resend_tbyt", TByt0, 8'h11);
        tick();
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
`else
        check("fin_busy", BUSY, 1'b0);
        tick();
`endif
        check("done_pulse_end", DONE, 1'b0);
        check("loader_x", lb[0], 8'h11);
        check("loader_y", lb[1], 8'h22);
        check("loader_zoom", lb[2], 8'h33);
        check("loader_angle", lb[3], 8'h44);
        tick();

        // Ack timeout
        set_frame(8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h05);
        start_frame();
        cyc = 1;
        while (cyc < FRAME + TO) begin
            tick();
            cyc++;
        end
        check("to_err_before", ERR, 1'b0);
        check("to_busy_before", BUSY, 1'b1);
        tick();
        check("to_err", ERR, 1'b1);
        check("to_busy", BUSY, 1'b0);
        check("to_tbyt_hold", TByt0, 8'h05);
        tick();

        // Next START clears ERR; abort during byte 2 drive
        set_frame(8'h5A, 8'h6B, 8'h7C, 8'h8D, 8'h00);
        start_frame();
        cyc = 1;
        check("restart_err_clear", ERR, 1'b0);
        while (cyc < 9) begin
            tick();
            cyc++;
        end
        check("ab_pre_tbyt", TByt0, 8'h7C);
        check("ab_pre_tvalid", TValid, 1'b1);
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        check("ab_tvalid", TValid, 1'b0);
        check("ab_busy", BUSY, 1'b0);
        check("ab_done", DONE, 1'b0);
        tick();
        tick();

        // Restart from byte 0, then reset during byte 3 gap
        set_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h05);
        start_frame();
        cyc = 1;
        check("rs_byte0", TByt0, 8'h01);
        while (cyc < 15) begin
            tick();
            cyc++;
        end
        check("gap3_tbyt", TByt0, 8'h04);
        check("gap3_tvalid", TValid, 1'b0);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check("midrst_tbyt", TByt0, 8'h00);
        check("midrst_tvalid", TValid, 1'b0);
        check("midrst_busy", BUSY, 1'b0);
        check("midrst_err", ERR, 1'b0);
        tick();

        // START pulses while busy are ignored; inputs change after acceptance; Count=0
        set_frame(8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'h00);
        start_frame();
        cyc = 1; rises = 0; last_hi = 0; prev = 1'b0;
        while (cyc <= 40) begin
            if (TValid && !prev) rises++;
            if (TValid) last_hi = cyc;
            prev = TValid;
            START = (cyc % 3 == 0);
            X_center = 8'(cyc);
            Count = 8'(cyc + 7);
            if (cyc == 17) check("cnt0_tbyt", TByt0, 8'h00);
            tick();
            cyc++;
        end
        START = 1'b0;
        check("one_frame_rises", rises, 5);
        check("one_frame_last_hi", last_hi, 18);
        check("busy_wait_ack", BUSY, 1'b1);
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        tick();
        tick();

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
